approx_mul_seq_ctrl: RTL and testbench
======================================

Name: approx_mul_seq_ctrl

Overview:
- Sequencer that builds an A_W x 8 approximate product by time-multiplexing one external approx_mul_2X8 datapath.
- Splits operand A into 2-bit slices, LSB first, and drives one slice plus B to the datapath per cycle.
- Accumulates each 10-bit partial product, shifted left by 2*k, into a result register.
- Sits between a valid/ready operand source and a valid/ready result sink.

Parameters:
- A_W, 8, width of operand A; even, >= 2; N = A_W/2 slices.
- EARLY_EXIT, 1, 1 = stop after the highest nonzero slice of A; 0 = always run N slices.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  A_W  multiplier operand A.
- in_b  in  8  multiplicand B.
- mul_a  out  2  slice of A to the datapath `a` input.
- mul_b  out  8  B to the datapath `b` input.
- mul_p  in  10  datapath product (myadder), combinational from mul_a/mul_b.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_res  out  A_W+8  accumulated product, modulo 2^(A_W+8).
- out_ovf  out  1  a carry beyond bit A_W+7 occurred during accumulation.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE, k=0, a_reg/b_reg/acc=0; out_valid=0, out_res=0, out_ovf=0, mul_a=0, mul_b=0, busy=0, in_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a_reg=in_a, b_reg=in_b; acc=0, ovf=0, k=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - mul_a=a_reg[2k+1:2k], mul_b=b_reg. mul_p is sampled in the same cycle.
  - Each cycle: {carry,acc} <= acc + (zero-extended mul_p << 2k), computed at A_W+11 bits. ovf is set sticky if any bit above A_W+7 is nonzero. acc keeps the low A_W+8 bits.
  - Last slice (EARLY_EXIT=0): k == N-1.
  - Last slice (EARLY_EXIT=1): k == N-1, or a_reg bits above 2k+1 are all zero.
  - On the last slice: go to DONE. Otherwise k <= k+1.
- DONE:
  - out_valid=1; out_res=acc; out_ovf=ovf. Both are stable while out_valid && !out_ready.
  - mul_a=0, mul_b=0.
  - On out_ready: out_valid drops next cycle; go to IDLE.
- mul_a and mul_b are 0 outside RUN.
- Latency from the accept edge to out_valid high:
  - EARLY_EXIT=0: N+1 cycles.
  - EARLY_EXIT=1: m+1 cycles, where m = index of the highest nonzero slice plus 1; m=1 if A=0.
- Throughput:
  - No overlap; in_ready is low from accept until the cycle after the result handshake.
  - Minimum initiation interval is latency+1, with out_ready tied high.
- A=0 or B=0: still performs one RUN cycle; result 0, ovf 0.
- The block adds whatever the datapath returns and does not correct approximation error.
- in_valid in RUN or DONE is ignored, with no capture. The source must hold its data until in_ready.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the pending result is discarded.
- out_res holds its last value after the DONE handshake until the next DONE. out_ovf likewise.

Test Plan:
- Real datapath, A_W=8, EARLY_EXIT=0; A=0x12, B=0x5A (no slice =11, so exact) -> 4 RUN cycles, mul_a sequence 2,0,1,0; out_res=0x0654, out_ovf=0, out_valid 5 cycles after accept.
- EARLY_EXIT=1; A=0x02, B=0xFF -> one RUN cycle, out_res=0x01FE, out_valid 2 cycles after accept; repeat with EARLY_EXIT=0 -> same result after 5 cycles.
- Approximation pass-through; A=0x03, B=0x03 -> datapath returns 7; out_res=0x0007, not 9.
- Overflow with a stub datapath returning 0x3FF every cycle; A=0xFF, EARLY_EXIT=0 -> sum 86955; out_res=0x53AB, out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_res stable, in_ready=0, a new in_valid is ignored; release -> in_ready=1 the following cycle.
- Drop rst_n at RUN cycle k=2 -> outputs immediately at reset values; next operand A=0x12, B=0x5A completes normally with 0x0654.

Source files
------------

// File: rtl/approx_mul_seq_ctrl.sv
// Sequencer producing an A_W x 8 approximate product by walking 2-bit
// slices of A through one external approx_mul_2X8 datapath.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b operand handshake;
// mul_a/mul_b/mul_p datapath link; out_valid/out_ready/out_res/out_ovf
// result handshake; busy high while a job is in RUN or DONE.
module approx_mul_seq_ctrl #(
  parameter int A_W        = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [7:0]     in_b,
  output logic [1:0]     mul_a,
  output logic [7:0]     mul_b,
  input  logic [9:0]     mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W+7:0] out_res,
  output logic           out_ovf,
  output logic           busy
);

  localparam int N  = A_W / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = A_W + 8;
  localparam int SW = A_W + 11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [KW-1:0]  k;
  logic [A_W-1:0] a_reg;
  logic [7:0]     b_reg;
  logic [RW-1:0]  acc;
  logic           ovf;
  logic [RW-1:0]  res_reg;
  logic           ovf_reg;

  logic [A_W-1:0] a_sh;
  logic [SW-1:0]  p_sh;
  logic [SW-1:0]  sum;
  logic           carry;
  logic           last;

  // a_sh puts the current slice in bits [1:0]; anything above it
  // is the still-unprocessed part of A used for early exit.
  always_comb begin
    a_sh  = a_reg >> {k, 1'b0};
    p_sh  = SW'(mul_p) << {k, 1'b0};
    sum   = SW'(acc) + p_sh;
    carry = |sum[SW-1:RW];
    last  = (k == KW'(N - 1));
    if (EARLY_EXIT) begin
      last = last | ((a_sh >> 2) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_a     = 2'b00;
    mul_b     = 8'h00;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        mul_a = a_sh[1:0];
        mul_b = b_reg;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // res_reg/ovf_reg are loaded only on the last slice, so the
  // previous result survives the next job's RUN phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      res_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            ovf   <= 1'b0;
            k     <= '0;
          end
        end
        RUN: begin
          acc <= sum[RW-1:0];
          ovf <= ovf | carry;
          if (last) begin
            res_reg <= sum[RW-1:0];
            ovf_reg <= ovf | carry;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_res = res_reg;
  assign out_ovf = ovf_reg;

endmodule

// File: tb/tb_approx_mul_seq_ctrl.sv
// Bench for approx_mul_seq_ctrl: two instances (EARLY_EXIT 0 and 1),
// each driving a behavioural approx_mul_2X8 datapath or a 0x3FF stub.
module tb_approx_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        stub;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_ovf   [2];
  logic        busy      [2];
  logic [1:0]  mul_a     [2];
  logic [7:0]  mul_b     [2];
  logic [9:0]  mul_p     [2];
  logic [15:0] out_res   [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // 2x8 datapath: exact for slices 0..2; slice 3 forms 2b|b,
  // so 3x3 yields 7.
  function automatic logic [9:0] dp(input logic [1:0] a,
                                    input logic [7:0] b,
                                    input logic s);
    if (s) return 10'h3FF;
    case (a)
      2'd0: return 10'd0;
      2'd1: return {2'b00, b};
      2'd2: return {1'b0, b, 1'b0};
      default: return {1'b0, b, 1'b0} | {2'b00, b};
    endcase
  endfunction

  always_comb mul_p[0] = dp(mul_a[0], mul_b[0], stub);
  always_comb mul_p[1] = dp(mul_a[1], mul_b[1], stub);

  approx_mul_seq_ctrl #(.A_W(8), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_res(out_res[0]), .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  approx_mul_seq_ctrl #(.A_W(8), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_res(out_res[1]), .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  // Reference: number of slices m, slice list and full sum.
  function automatic int n_slices(input int i, input logic [7:0] a);
    int m;
    if (i == 0) return 4;
    m = 1;
    for (int s = 0; s < 4; s++)
      if (((a >> (2 * s)) & 8'h3) != 0) m = s + 1;
    return m;
  endfunction

  function automatic int ref_sum(input int i, input logic [7:0] a,
                                 input logic [7:0] b, input logic s);
    int t;
    logic [1:0] sl;
    t = 0;
    for (int j = 0; j < n_slices(i, a); j++) begin
      sl = 2'((a >> (2 * j)) & 8'h3);
      t = t + (int'(dp(sl, b, s)) * (4 ** j));
    end
    return t;
  endfunction

  task automatic do_txn(input int i, input logic [7:0] a,
                        input logic [7:0] b, input string tag);
    int m, tot, lat, kk, n;
    logic [15:0] er;
    logic eo;
    logic [1:0] es;
    m   = n_slices(i, a);
    tot = ref_sum(i, a, b, stub);
    er  = 16'(tot);
    eo  = (tot > 65535);
    in_a = a;
    in_b = b;
    in_valid[i] = 1'b1;
    n = 0;
    while (!in_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid[i] = 1'b0;
    lat = 1;
    kk  = 0;
    while (!out_valid[i] && lat < 40) begin
      es = 2'((a >> (2 * kk)) & 8'h3);
      checks++;
      if (kk >= 4 || mul_a[i] !== es || mul_b[i] !== b || busy[i] !== 1'b1) begin
        fails++;
        $display("FAIL %s run k=%0d: mul_a=%0d mul_b=%h busy=%b, want mul_a=%0d mul_b=%h busy=1",
                 tag, kk, mul_a[i], mul_b[i], busy[i], es, b);
      end
      kk++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== m + 1 || kk !== m) begin
      fails++;
      $display("FAIL %s latency: got %0d (run %0d), want %0d (run %0d)",
               tag, lat, kk, m + 1, m);
    end
    checks++;
    if (out_res[i] !== er || out_ovf[i] !== eo) begin
      fails++;
      $display("FAIL %s result: got %h ovf=%b, want %h ovf=%b",
               tag, out_res[i], out_ovf[i], er, eo);
    end
    checks++;
    if (in_ready[i] !== 1'b0 || mul_a[i] !== 2'd0 || mul_b[i] !== 8'd0 || busy[i] !== 1'b1) begin
      fails++;
      $display("FAIL %s done outs: in_ready=%b mul_a=%0d mul_b=%h busy=%b, want 0 0 00 1",
               tag, in_ready[i], mul_a[i], mul_b[i], busy[i]);
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    checks++;
    if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || busy[i] !== 1'b0 || out_res[i] !== er) begin
      fails++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b res=%h, want 0 1 0 %h",
               tag, out_valid[i], in_ready[i], busy[i], out_res[i], er);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 ||
          mul_a[i] !== 2'd0 || mul_b[i] !== 8'd0 ||
          out_res[i] !== 16'd0 || out_ovf[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: rdy=%b vld=%b busy=%b ma=%0d mb=%h res=%h ovf=%b",
                 i, in_ready[i], out_valid[i], busy[i], mul_a[i], mul_b[i],
                 out_res[i], out_ovf[i]);
      end
    end
  endtask

  task automatic test_directed();
    do_txn(0, 8'h12, 8'h5A, "exact_full");
    checks++;
    if (out_res[0] !== 16'h0654) begin
      fails++;
      $display("FAIL exact_const: got %h want 0654", out_res[0]);
    end
    do_txn(1, 8'h02, 8'hFF, "early_02");
    checks++;
    if (out_res[1] !== 16'h01FE) begin
      fails++;
      $display("FAIL early_const: got %h want 01fe", out_res[1]);
    end
    do_txn(0, 8'h02, 8'hFF, "full_02");
    do_txn(1, 8'h03, 8'h03, "approx_33");
    checks++;
    if (out_res[1] !== 16'h0007) begin
      fails++;
      $display("FAIL approx_const: got %h want 0007", out_res[1]);
    end
    do_txn(1, 8'h00, 8'hA5, "a_zero");
    do_txn(0, 8'hC3, 8'h00, "b_zero");
  endtask

  task automatic test_overflow();
    stub = 1'b1;
    do_txn(0, 8'hFF, 8'(($urandom)), "ovf_stub");
    checks++;
    if (out_res[0] !== 16'h53AB || out_ovf[0] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_const: got %h/%b want 53ab/1", out_res[0], out_ovf[0]);
    end
    stub = 1'b0;
    do_txn(0, 8'h01, 8'h10, "ovf_clears");
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] r0;
    in_a = 8'hB6;
    in_b = 8'h3C;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    r0 = 16'(ref_sum(0, 8'hB6, 8'h3C, 1'b0));
    for (int c = 0; c < 10; c++) begin
      in_a = 8'(($urandom));
      in_b = 8'(($urandom));
      in_valid[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || out_res[0] !== r0 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        fails++;
        $display("FAIL hold c=%0d: vld=%b res=%h rdy=%b busy=%b, want 1 %h 0 1",
                 c, out_valid[0], out_res[0], in_ready[0], busy[0], r0);
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_res[0] !== r0) begin
      fails++;
      $display("FAIL bp_release: rdy=%b vld=%b res=%h, want 1 0 %h",
               in_ready[0], out_valid[0], out_res[0], r0);
    end
    // an operand seen in DONE must not have started a new job
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || mul_b[0] !== 8'd0) begin
      fails++;
      $display("FAIL bp_nocapture: busy=%b mul_b=%h, want 0 00", busy[0], mul_b[0]);
    end
  endtask

  task automatic test_reset_midrun();
    in_a = 8'h12;
    in_b = 8'h5A;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mul_a[0] !== 2'd1 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrun k2: mul_a=%0d busy=%b, want 1 1", mul_a[0], busy[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    do_txn(0, 8'h12, 8'h5A, "after_rst");
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int it = 0; it < 40; it++) begin
      a = 8'(($urandom));
      if (it % 3 == 0) a = a & 8'h0F;
      if (it % 7 == 0) a = a & 8'h03;
      do_txn(it % 2, a, 8'(($urandom)), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stub  = 1'b0;
    in_a  = '0;
    in_b  = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_overflow();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
